// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
// Registers the ID->EX bus, runs the ALU, drives the data-SRAM request,
// exposes the EX forwarding tap, and owns HI/LO plus a 32-step restoring
// divider.
// Optional feature macro: EX_MULT_EN (single-cycle MULT/MULTU into HI/LO).
//
// Handshake: stallreq_for_ex is high while a DIV/DIVU sits in EX and its
// result is not ready. The pipeline controller answers through stall[];
// stall[2]=1 with stall[3]=1 holds EX, stall[2]=1 with stall[3]=0 loads
// a bubble, and stall[2]=0 lets EX advance and commit HI/LO.
module ex_stage #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 76,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    ex_wreg,
    output logic [4:0]              ex_waddr,
    output logic [31:0]             ex_wdata,
    output logic                    stallreq_for_ex,
    output logic [1:0]              div_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    logic [ID_TO_EX_WD-1:0] id_ex_q;

    logic [31:0] pc, inst, rdata1, rdata2;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic [3:0]  sel_alu_src2;
    logic        data_ram_en, rf_we, sel_rf_res;
    logic [3:0]  data_ram_wen;
    logic [4:0]  rf_waddr;

    // Pipeline register: async clear, bubble on EX-stall/MEM-go, hold on full stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     id_ex_q <= '0;
        else if (stall[2] && !stall[3]) id_ex_q <= '0;
        else if (!stall[2])           id_ex_q <= id_to_ex_bus;
    end

    assign pc           = id_ex_q[158:127];
    assign inst         = id_ex_q[126:95];
    assign alu_op       = id_ex_q[94:83];
    assign sel_alu_src1 = id_ex_q[82:80];
    assign sel_alu_src2 = id_ex_q[79:76];
    assign data_ram_en  = id_ex_q[75];
    assign data_ram_wen = id_ex_q[74:71];
    assign rf_we        = id_ex_q[70];
    assign rf_waddr     = id_ex_q[69:65];
    assign sel_rf_res   = id_ex_q[64];
    assign rdata1       = id_ex_q[63:32];
    assign rdata2       = id_ex_q[31:0];

    // Operand muxes are AND-OR so an empty select yields zero.
    logic [31:0] src1, src2;
    assign src1 = ({32{sel_alu_src1[0]}} & rdata1)
                | ({32{sel_alu_src1[1]}} & pc)
                | ({32{sel_alu_src1[2]}} & {27'd0, inst[10:6]});
    assign src2 = ({32{sel_alu_src2[0]}} & rdata2)
                | ({32{sel_alu_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
                | ({32{sel_alu_src2[2]}} & 32'd8)
                | ({32{sel_alu_src2[3]}} & {16'd0, inst[15:0]});

    logic [31:0] add_r, sub_r, slt_r, sltu_r, sll_r, srl_r, sra_r, lui_r, alu_res;
    assign add_r  = src1 + src2;
    assign sub_r  = src1 - src2;
    assign slt_r  = {31'd0, $signed(src1) < $signed(src2)};
    assign sltu_r = {31'd0, src1 < src2};
    assign sll_r  = src2 << src1[4:0];
    assign srl_r  = src2 >> src1[4:0];
    assign sra_r  = $unsigned($signed(src2) >>> src1[4:0]);
    assign lui_r  = {src2[15:0], 16'h0};

    assign alu_res = ({32{alu_op[11]}} & add_r)
                   | ({32{alu_op[10]}} & sub_r)
                   | ({32{alu_op[9]}}  & slt_r)
                   | ({32{alu_op[8]}}  & sltu_r)
                   | ({32{alu_op[7]}}  & (src1 & src2))
                   | ({32{alu_op[6]}}  & ~(src1 | src2))
                   | ({32{alu_op[5]}}  & (src1 | src2))
                   | ({32{alu_op[4]}}  & (src1 ^ src2))
                   | ({32{alu_op[3]}}  & sll_r)
                   | ({32{alu_op[2]}}  & srl_r)
                   | ({32{alu_op[1]}}  & sra_r)
                   | ({32{alu_op[0]}}  & lui_r);

    // HI/LO instruction decode (SPECIAL opcode, function field).
    logic special, op_div, op_divu, op_any_div, op_mfhi, op_mflo, op_mthi, op_mtlo;
    assign special    = (inst[31:26] == 6'd0);
    assign op_div     = special && (inst[5:0] == 6'b011010);
    assign op_divu    = special && (inst[5:0] == 6'b011011);
    assign op_mfhi    = special && (inst[5:0] == 6'b010000);
    assign op_mflo    = special && (inst[5:0] == 6'b010010);
    assign op_mthi    = special && (inst[5:0] == 6'b010001);
    assign op_mtlo    = special && (inst[5:0] == 6'b010011);
    assign op_any_div = op_div | op_divu;

    logic [31:0] hi_q, lo_q;

    // Divider state and datapath.
    div_state_t  state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] quo_q, rem_q, dvs_q;
    logic        neg_quo_q, neg_rem_q;
    logic [31:0] abs_a, abs_b;
    logic [32:0] shifted, diff;
    logic        fits;
    logic [31:0] div_hi, div_lo;

    assign abs_a   = (op_div && rdata1[31]) ? (32'd0 - rdata1) : rdata1;
    assign abs_b   = (op_div && rdata2[31]) ? (32'd0 - rdata2) : rdata2;
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign fits    = ~diff[32];
    assign div_hi  = neg_rem_q ? (32'd0 - rem_q) : rem_q;
    assign div_lo  = neg_quo_q ? (32'd0 - quo_q) : quo_q;

    // Divider state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Divider next-state: zero divisor skips straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (op_any_div) state_d = (rdata2 == 32'd0) ? S_DONE : S_RUN;
            S_RUN:  if (cnt_q == 5'd31) state_d = S_DONE;
            S_DONE: if (!stall[2]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Divider datapath: latch magnitudes, then one restoring step per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= 5'd0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            dvs_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_any_div) begin
                        cnt_q <= 5'd0;
                        if (rdata2 == 32'd0) begin
                            quo_q     <= 32'hFFFF_FFFF;
                            rem_q     <= rdata1;
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                        end else begin
                            quo_q     <= abs_a;
                            rem_q     <= 32'd0;
                            dvs_q     <= abs_b;
                            neg_quo_q <= op_div & (rdata1[31] ^ rdata2[31]);
                            neg_rem_q <= op_div & rdata1[31];
                        end
                    end
                end
                S_RUN: begin
                    rem_q <= fits ? diff[31:0] : shifted[31:0];
                    quo_q <= {quo_q[30:0], fits};
                    cnt_q <= cnt_q + 5'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef EX_MULT_EN
    logic        op_mult, op_multu;
    logic [63:0] prod;
    assign op_mult  = special && (inst[5:0] == 6'b011000);
    assign op_multu = special && (inst[5:0] == 6'b011001);
    assign prod = op_mult ? ({{32{rdata1[31]}}, rdata1} * {{32{rdata2[31]}}, rdata2})
                          : ({32'd0, rdata1} * {32'd0, rdata2});
`endif

    // HI/LO commit when EX advances; a finished division takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (!stall[2]) begin
            if (state_q == S_DONE) begin
                hi_q <= div_hi;
                lo_q <= div_lo;
            end else if (op_mthi) begin
                hi_q <= rdata1;
            end else if (op_mtlo) begin
                lo_q <= rdata1;
            end
`ifdef EX_MULT_EN
            else if (op_mult || op_multu) begin
                hi_q <= prod[63:32];
                lo_q <= prod[31:0];
            end
`endif
        end
    end

    logic [31:0] ex_result;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    assign ex_result  = op_mfhi ? hi_q : (op_mflo ? lo_q : alu_res);
    assign rf_we_o    = rf_we | op_mfhi | op_mflo;
    assign rf_waddr_o = (op_mfhi | op_mflo) ? inst[15:11] : rf_waddr;

    assign ex_to_mem_bus   = {pc, data_ram_en, data_ram_wen, sel_rf_res,
                              rf_we_o, rf_waddr_o, ex_result};
    assign data_sram_en    = data_ram_en;
    assign data_sram_wen   = data_ram_wen;
    assign data_sram_addr  = alu_res;
    assign data_sram_wdata = rdata2;
    assign ex_wreg         = rf_we_o;
    assign ex_waddr        = rf_waddr_o;
    assign ex_wdata        = ex_result;
    assign stallreq_for_ex = op_any_div && (state_q != S_DONE);
    assign div_state       = state_q;

    logic unused_ok;
    assign unused_ok = ^{stall[STALL_WD-1:4], stall[1:0], inst[25:16]};

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Registers the ID→EX bus and computes the ALU result, data-SRAM request and EX forwarding tap.
- Holds the HI/LO registers and a 32-iteration radix-2 divider; raises a stall request while a division is in flight.
- Feeds the MEM stage through ex_to_mem_bus.

Parameters:
- ID_TO_EX_WD, 159, width of id_to_ex_bus.
- EX_TO_MEM_WD, 76, width of ex_to_mem_bus.
- STALL_WD, 6, width of stall bus.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- stall  in  STALL_WD  stall vector; bit2 = EX, bit3 = MEM; 1 = Stop
- id_to_ex_bus  in  ID_TO_EX_WD  fields, MSB→LSB: pc[158:127], inst[126:95], alu_op[94:83], sel_alu_src1[82:80], sel_alu_src2[79:76], data_ram_en[75], data_ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0]
- ex_to_mem_bus  out  EX_TO_MEM_WD  fields, MSB→LSB: pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]
- data_sram_en  out  1  data SRAM enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  = alu result
- data_sram_wdata  out  32  = rdata2
- ex_wreg, ex_waddr, ex_wdata  out  1/5/32  forwarding tap to ID
- stallreq_for_ex  out  1  division in progress

Behaviour:
- Input register, updated on posedge clk:
  - rst low → cleared asynchronously.
  - Else stall[2]=1 & stall[3]=0 → loaded with zero (bubble).
  - Else stall[2]=0 → loaded with id_to_ex_bus.
  - Else hold.
- src1 mux, one-hot sel_alu_src1: [0] rdata1, [1] pc, [2] zero-extended inst[10:6].
- src2 mux, one-hot sel_alu_src2: [0] rdata2, [1] sign-extended inst[15:0], [2] 32'd8, [3] zero-extended inst[15:0].
- No select bit set → operand is 0.
- alu_op bits [11..0] = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Results are AND-OR merged; add/sub wrap mod 2^32.
  - slt signed, sltu unsigned, each giving 0/1.
  - Shifts: src2 shifted by src1[4:0].
  - lui = {src2[15:0], 16'h0}.
- HI/LO instructions, decoded from inst with opcode 0:
  - func 011010 DIV, 011011 DIVU.
  - 010000 MFHI, 010010 MFLO: ex_result = HI/LO; rf_we forced to 1; rf_waddr forced to inst[15:11].
  - 010001 MTHI, 010011 MTLO: HI/LO ← rdata1 at the edge where stall[2]=0.
- Divider FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when a DIV/DIVU is in EX and divisor ≠ 0. Operand magnitudes are latched and the 5-bit counter is cleared.
  - RUN: one restoring-division step per cycle; after 32 steps → DONE.
  - Divisor = 0 → IDLE → DONE directly; result is HI = rdata1, LO = 32'hFFFFFFFF.
  - Signed fix-up for DIV: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - DONE: HI ← remainder, LO ← quotient at the first edge with stall[2]=0, then → IDLE. DONE holds while stall[2]=1.
- Latency: DIV enters EX at cycle T, RUN during T+1..T+32, DONE at T+33.
- stallreq_for_ex = DIV/DIVU in EX & state≠DONE (combinational); high T..T+32, low at T+33.
- An instruction following DIV/MT* sees the updated HI/LO with no forwarding needed.
- data_sram_* driven combinationally from the registered fields; a bubble gives en = 0, wen = 0.
- ex_wreg / ex_waddr / ex_wdata = registered-and-overridden rf_we, rf_waddr, ex_result.
- Reset (including mid-division): FSM → IDLE, counter 0, HI = LO = 0, all outputs 0.

Optional Feature:
- Macro EX_MULT_EN.
- Defined:
  - MULT (func 011000) and MULTU (011001) compute a 64-bit product combinationally in one cycle.
  - {HI, LO} ← product at the edge where stall[2]=0; no stall request.
- Undefined: MULT/MULTU leave HI/LO unchanged and act as no-ops.

Test Plan:
- ori, src1 = rdata1 = 32'h0000_1200, imm = 16'h0034, op_or → ex_result = 32'h0000_1234, rf_we = 1, ex_wdata matches.
- jal: pc = 32'hBFC0_0000, src2 = 8, op_add → ex_result = 32'hBFC0_0008, rf_waddr = 31.
- DIV rs = -7, rt = 2 → stallreq high for 33 cycles. MFLO then gives 32'hFFFF_FFFD and MFHI gives 32'hFFFF_FFFF.
- DIVU rs = 100, rt = 0 → stallreq for exactly 1 cycle, then HI = 100, LO = 32'hFFFF_FFFF.
- rst pulled low at RUN cycle 10, then released → state IDLE, HI = LO = 0, stallreq = 0, ex_to_mem_bus = 0.
- stall[2] = 1 with stall[3] = 0 → next cycle ex_to_mem_bus = 0 and data_sram_en = 0. With EX_MULT_EN: MULTU 32'hFFFF_FFFF × 2 → HI = 1, LO = 32'hFFFF_FFFE.
